legv8_imm_encoder: RTL and testbench

//   Packs a format tag, register fields and a signed 64-bit immediate into a 32-bit LEGv8 instruction word (B, CBZ, D formats).
//   It is the inverse of the datapath's immediate sign-extension: decode(encode(x)) == x for every in-range immediate.

---
 rtl/legv8_imm_encoder.sv | 120 ++++++++++++
 tb/tb_legv8_imm_encoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_imm_encoder.sv
// LEGv8 immediate encoder: packs B/CBZ/D instruction words from a signed immediate
// and streams them with byte addresses into instruction memory, one burst per start.
module legv8_imm_encoder #(
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 12,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [CNT_W-1:0]    start_count,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_fmt,
    input  logic [10:0]         in_opc,
    input  logic [4:0]          in_rt,
    input  logic [4:0]          in_rn,
    input  logic [63:0]         in_imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                done,
    output logic [ERRCNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_rem;
    logic [ERRCNT_W-1:0] r_err_cnt;
    logic                r_out_valid;
    logic [31:0]         r_out_instr;
    logic [ADDR_W-1:0]   r_out_addr;

    logic [31:0]         w_instr;
    logic                w_good;
    logic                w_accept;

    // An immediate fits when every bit above the field's sign bit equals that sign bit.
    always_comb begin
        w_instr = '0;
        w_good  = 1'b0;
        case (in_fmt)
            2'd0: begin
                w_instr = {6'b000101, in_imm[25:0]};
                w_good  = (&in_imm[63:25]) | ~(|in_imm[63:25]);
            end
            2'd1: begin
                w_instr = {8'b10110100, in_imm[18:0], in_rt};
                w_good  = (&in_imm[63:18]) | ~(|in_imm[63:18]);
            end
            2'd2: begin
                w_instr = {in_opc, in_imm[8:0], 2'b00, in_rn, in_rt};
                w_good  = (&in_imm[63:8]) | ~(|in_imm[63:8]);
            end
            default: begin
                w_instr = '0;
                w_good  = 1'b0;
            end
        endcase
    end

    assign in_ready  = (r_state == S_LOAD) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign done      = (r_state == S_DONE);
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err_cnt   = r_err_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (start_count != '0) ? S_LOAD : S_DONE;
            S_LOAD:  if (w_accept && (r_rem == CNT_W'(1))) w_next = S_DRAIN;
            S_DRAIN: if (!r_out_valid || out_ready) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rem       <= '0;
            r_err_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_addr    <= {start_addr[ADDR_W-1:2], 2'b00};
                r_rem     <= start_count;
                r_err_cnt <= '0;
            end
            if (w_accept) begin
                r_rem <= r_rem - CNT_W'(1);
                if (w_good)
                    r_addr <= r_addr + ADDR_W'(4);
                else if (r_err_cnt != '1)
                    r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
            end
            // A new good word may replace one being consumed this same cycle.
            if (w_accept && w_good) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
                r_out_addr  <= r_addr;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_legv8_imm_encoder.sv
// Directed bench for legv8_imm_encoder: encodings, range errors, backpressure,
// empty burst, mid-burst reset, address wrap and error-counter saturation.
module tb_legv8_imm_encoder;

    localparam int ADDR_W   = 16;
    localparam int CNT_W    = 12;
    localparam int ERRCNT_W = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [ADDR_W-1:0]   start_addr;
    logic [CNT_W-1:0]    start_count;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_fmt;
    logic [10:0]         in_opc;
    logic [4:0]          in_rt;
    logic [4:0]          in_rn;
    logic [63:0]         in_imm;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_instr;
    logic [ADDR_W-1:0]   out_addr;
    logic                done;
    logic [ERRCNT_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    legv8_imm_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .ERRCNT_W(ERRCNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .start_count(start_count), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opc(in_opc), .in_rt(in_rt), .in_rn(in_rn),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .done(done), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] fmt, input logic [10:0] opc, input logic [4:0] rt,
                        input logic [4:0] rn, input logic [63:0] imm);
        int waited;
        in_fmt = fmt; in_opc = opc; in_rt = rt; in_rn = rn; in_imm = imm;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("send_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
        tick();
        chk({tag, "_clear"}, done, 0);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] c);
        start_addr = a; start_count = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] imm;
        logic [63:0] dec;
        logic [1:0]  fmt;
        logic [4:0]  rt, rn;
        logic [10:0] opc;
        logic [ADDR_W-1:0] exp_addr;
        int pulses, ov_seen, accepts, n;

        rst_n = 1'b0; start = 1'b0; start_addr = '0; start_count = '0;
        in_valid = 1'b0; in_fmt = '0; in_opc = '0; in_rt = '0; in_rn = '0; in_imm = '0;
        out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", out_addr, 0);
        rst_n = 1'b1;
        tick();

        // Basic three-format burst
        do_start(16'h0100, 3);
        chk("t1_in_ready", in_ready, 1);
        send(2'd0, 11'h000, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_b_instr", out_instr, 32'h17FF_FFFF);
        chk("t1_b_addr", out_addr, 16'h0100);
        send(2'd1, 11'h000, 5'd3, 5'd0, 64'd5);
        chk("t1_cbz_instr", out_instr, 32'hB400_00A3);
        chk("t1_cbz_addr", out_addr, 16'h0104);
        send(2'd2, 11'h7C2, 5'd2, 5'd1, -64'sd4);
        chk("t1_d_instr", out_instr, 32'hF85F_C022);
        chk("t1_d_addr", out_addr, 16'h0108);
        chk("t1_done_early", done, 0);
        wait_done("t1_done");
        chk("t1_err_cnt", err_cnt, 0);

        // CBZ range boundary: +2^18 rejected, -2^18 accepted at unadvanced address
        do_start(16'h0200, 2);
        send(2'd1, 11'h000, 5'd7, 5'd0, 64'h0000_0000_0004_0000);
        chk("t2_err_cnt1", err_cnt, 1);
        chk("t2_err_no_out", out_valid, 0);
        send(2'd1, 11'h000, 5'd7, 5'd0, -64'sh40000);
        chk("t2_cbz_instr", out_instr, 32'hB480_0007);
        chk("t2_cbz_addr", out_addr, 16'h0200);
        chk("t2_err_cnt_hold", err_cnt, 1);
        wait_done("t2_done");

        // Backpressure with a stray start pulse outside IDLE
        out_ready = 1'b0;
        do_start(16'h0300, 2);
        chk("t3_err_cleared", err_cnt, 0);
        send(2'd2, 11'h7C0, 5'd3, 5'd2, 64'd255);
        chk("t3_d1_valid", out_valid, 1);
        chk("t3_d1_instr", out_instr, 32'hF80F_F043);
        in_fmt = 2'd2; in_opc = 11'h7C2; in_rt = 5'd0; in_rn = 5'd31; in_imm = -64'sd256;
        in_valid = 1'b1;
        start = 1'b1; start_addr = 16'h0700; start_count = 9;
        for (int unsigned i = 0; i < 5; i++) begin
            chk("t3_hold_ready", in_ready, 0);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_instr", out_instr, 32'hF80F_F043);
            chk("t3_hold_addr", out_addr, 16'h0300);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t3_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t3_d2_valid", out_valid, 1);
        chk("t3_d2_instr", out_instr, 32'hF850_03E0);
        chk("t3_d2_addr", out_addr, 16'h0304);
        wait_done("t3_done");

        // Empty burst
        do_start(16'h0000, 0);
        pulses = 0; ov_seen = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (done) pulses++;
            if (out_valid) ov_seen++;
            tick();
        end
        chk("t4_done_pulses", pulses, 1);
        chk("t4_no_out_valid", ov_seen, 0);

        // Reset mid-burst with a pending word and nonzero error count
        out_ready = 1'b0;
        do_start(16'h0400, 3);
        send(2'd3, 11'h000, 5'd0, 5'd0, 64'd0);
        chk("t5_err_cnt", err_cnt, 1);
        send(2'd0, 11'h000, 5'd0, 5'd0, 64'd8);
        chk("t5_b_instr", out_instr, 32'h1400_0008);
        chk("t5_b_addr", out_addr, 16'h0400);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", in_ready, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_err", err_cnt, 0);
        chk("t5_rst_instr", out_instr, 0);
        chk("t5_rst_addr", out_addr, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        do_start(16'h0500, 1);
        send(2'd0, 11'h000, 5'd0, 5'd0, 64'h0000_0000_01FF_FFFF);
        chk("t5_b_max_instr", out_instr, 32'h15FF_FFFF);
        chk("t5_b_max_addr", out_addr, 16'h0500);
        wait_done("t5_done");

        // Random in-range beats, misaligned start forced to alignment, address wrap
        do_start(16'hFFFB, 6);
        exp_addr = 16'hFFF8;
        for (int unsigned i = 0; i < 6; i++) begin
            r = {$urandom, $urandom};
            fmt = 2'(i % 3);
            rt = 5'($urandom_range(0, 31));
            rn = 5'($urandom_range(0, 31));
            opc = 11'($urandom_range(0, 2047));
            case (fmt)
                2'd0:    imm = {{38{r[25]}}, r[25:0]};
                2'd1:    imm = {{45{r[18]}}, r[18:0]};
                default: imm = {{55{r[8]}}, r[8:0]};
            endcase
            send(fmt, opc, rt, rn, imm);
            case (fmt)
                2'd0: begin
                    dec = {{38{out_instr[25]}}, out_instr[25:0]};
                    chk("t6_b_op", out_instr[31:26], 6'b000101);
                end
                2'd1: begin
                    dec = {{45{out_instr[23]}}, out_instr[23:5]};
                    chk("t6_cbz_op", out_instr[31:24], 8'hB4);
                    chk("t6_cbz_rt", out_instr[4:0], rt);
                end
                default: begin
                    dec = {{55{out_instr[20]}}, out_instr[20:12]};
                    chk("t6_d_fields", {out_instr[31:21], out_instr[11:0]}, {opc, 2'b00, rn, rt});
                end
            endcase
            chk("t6_decode", dec, imm);
            chk("t6_addr", out_addr, exp_addr);
            exp_addr = exp_addr + 16'd4;
        end
        wait_done("t6_done");

        // Error counter saturation over 257 reserved-format beats
        do_start(16'h0000, 257);
        in_fmt = 2'd3; in_valid = 1'b1;
        accepts = 0; n = 0;
        while (accepts < 257 && n < 400) begin
            if (in_ready) accepts++;
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("t7_accepts", accepts, 257);
        chk("t7_err_sat", err_cnt, 8'hFF);
        chk("t7_no_out", out_valid, 0);
        wait_done("t7_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
